fetch_exec_ctrl: RTL and testbench

FETCH_EXEC_CTRL -- requirements
Module: fetch_exec_ctrl

---
 rtl/fetch_exec_ctrl_if.sv | 51 +++++
 rtl/fetch_exec_ctrl.sv | 151 +++++++++++++++
 tb/tb_fetch_exec_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_exec_ctrl_if.sv
// fetch_exec_ctrl_if
//   Groups the controller's program-ROM, ALU, I/O and status signals
//   into one bundle. Clock and reset stay outside as plain ports.
//
//   master : the fetch/execute controller
//   slave  : the surrounding ROM, ALU and I/O logic
//
//   run        ctrl <- env   1 = advance, 0 = hold all state
//   prog_byte  ctrl <- env   program ROM data at address pc
//   pc         ctrl -> env   program counter / ROM address
//   alu_sel    ctrl -> env   ALU operation select
//   alu_a      ctrl -> env   ALU operand A (accumulator)
//   alu_b      ctrl -> env   ALU operand B
//   alu_y      ctrl <- env   ALU result
//   alu_c      ctrl <- env   ALU carry/borrow
//   alu_zero   ctrl <- env   ALU zero flag
//   data_in    ctrl <- env   input port
//   data_out   ctrl -> env   output port register
//   out_we     ctrl -> env   one-cycle strobe, data_out updated
//   acc        ctrl -> env   accumulator
//   flag_c     ctrl -> env   carry flag
//   flag_z     ctrl -> env   zero flag
//   state      ctrl -> env   FETCH=00, EXEC=01, ADDR=10
interface fetch_exec_ctrl_if;
  logic        run;
  logic [7:0]  prog_byte;
  logic [11:0] pc;
  logic [2:0]  alu_sel;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_y;
  logic        alu_c;
  logic        alu_zero;
  logic [3:0]  data_in;
  logic [3:0]  data_out;
  logic        out_we;
  logic [3:0]  acc;
  logic        flag_c;
  logic        flag_z;
  logic [1:0]  state;

  modport master (
    input  run, prog_byte, alu_y, alu_c, alu_zero, data_in,
    output pc, alu_sel, alu_a, alu_b, data_out, out_we, acc, flag_c, flag_z, state
  );

  modport slave (
    output run, prog_byte, alu_y, alu_c, alu_zero, data_in,
    input  pc, alu_sel, alu_a, alu_b, data_out, out_we, acc, flag_c, flag_z, state
  );
endinterface

// File: rtl/fetch_exec_ctrl.sv
// fetch_exec_ctrl
//   Fetch/execute sequencer for a 4-bit accumulator machine with an
//   8-bit instruction byte and a 12-bit program address. One-byte
//   instructions take FETCH+EXEC; jumps take FETCH+ADDR, where the
//   second ROM byte supplies the low eight target bits.
//
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous reset, active-low
//   bus    master side of fetch_exec_ctrl_if (ROM, ALU, I/O, status)
module fetch_exec_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  fetch_exec_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    ADDR  = 2'b10
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_SUB  = 3'b001;
  localparam logic [2:0] SEL_PASS = 3'b010;
  localparam logic [2:0] SEL_ADD  = 3'b011;
  localparam logic [2:0] SEL_NAND = 3'b100;

  state_t      st;
  logic [7:0]  ir;
  logic [11:0] pc_q;
  logic [3:0]  acc_q;
  logic        c_q;
  logic        z_q;
  logic [3:0]  dout_q;
  logic        we_q;

  logic [3:0]  opcode;
  logic [3:0]  imm;
  logic [2:0]  sel_d;
  logic [3:0]  b_d;
  logic        take_jump;
  logic        is_jump_byte;

  assign opcode = ir[7:4];
  assign imm    = ir[3:0];

  // Opcodes 8..C carry a second address byte and go through ADDR.
  assign is_jump_byte = (bus.prog_byte[7:4] >= 4'h8) && (bus.prog_byte[7:4] <= 4'hC);

  // ALU operation decode. The ALU is combinational outside this block,
  // so its result must be valid during EXEC for the closing-edge write;
  // outside EXEC the select is parked at 000.
  always_comb begin
    sel_d = SEL_NONE;
    b_d   = imm;
    if (opcode == 4'h6) begin
      b_d = bus.data_in;
    end
    if (st == EXEC) begin
      case (opcode)
        4'h1:    sel_d = SEL_PASS;
        4'h2:    sel_d = SEL_ADD;
        4'h3:    sel_d = SEL_SUB;
        4'h4:    sel_d = SEL_SUB;
        4'h5:    sel_d = SEL_NAND;
        4'h6:    sel_d = SEL_PASS;
        default: sel_d = SEL_NONE;
      endcase
    end
  end

  // Jump condition, evaluated from the flags as they stood before ADDR.
  always_comb begin
    take_jump = 1'b0;
    case (opcode)
      4'h8:    take_jump = 1'b1;
      4'h9:    take_jump = c_q;
      4'hA:    take_jump = z_q;
      4'hB:    take_jump = ~c_q;
      4'hC:    take_jump = ~z_q;
      default: take_jump = 1'b0;
    endcase
  end

  // Sequencer and architectural state. run=0 freezes everything but
  // still lets the out_we strobe fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= FETCH;
      ir     <= 8'h00;
      pc_q   <= 12'h000;
      acc_q  <= 4'h0;
      c_q    <= 1'b0;
      z_q    <= 1'b0;
      dout_q <= 4'h0;
      we_q   <= 1'b0;
    end else if (!bus.run) begin
      we_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (st)
        FETCH: begin
          ir   <= bus.prog_byte;
          pc_q <= pc_q + 12'd1;
          st   <= is_jump_byte ? ADDR : EXEC;
        end
        EXEC: begin
          case (opcode)
            4'h1, 4'h5, 4'h6: begin
              acc_q <= bus.alu_y;
              z_q   <= bus.alu_zero;
            end
            4'h2, 4'h3: begin
              acc_q <= bus.alu_y;
              c_q   <= bus.alu_c;
              z_q   <= bus.alu_zero;
            end
            4'h4: begin
              c_q <= bus.alu_c;
              z_q <= bus.alu_zero;
            end
            4'h7: begin
              dout_q <= acc_q;
              we_q   <= 1'b1;
            end
            default: begin
            end
          endcase
          st <= FETCH;
        end
        ADDR: begin
          pc_q <= take_jump ? {ir[3:0], bus.prog_byte} : (pc_q + 12'd1);
          st   <= FETCH;
        end
        default: st <= FETCH;
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.alu_sel  = sel_d;
  assign bus.alu_a    = acc_q;
  assign bus.alu_b    = b_d;
  assign bus.data_out = dout_q;
  assign bus.out_we   = we_q;
  assign bus.acc      = acc_q;
  assign bus.flag_c   = c_q;
  assign bus.flag_z   = z_q;
  assign bus.state    = st;

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// tb_fetch_exec_ctrl
//   Bench for fetch_exec_ctrl: a 4 KiB ROM and a 4-bit ALU model sit
//   around the controller. A table of short programs is run from reset
//   and the resulting architectural state compared against hand-worked
//   values; directed sequences cover reset mid-instruction, the out_we
//   pulse with run held low, and the 0xFFF->0x000 pc wrap.
module tb_fetch_exec_ctrl;

  logic clk;
  logic rst_n;

  fetch_exec_ctrl_if bus ();

  fetch_exec_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] rom [4096];

  int vec_count;
  int miss_count;

  typedef struct {
    string       name;
    logic [31:0] prog;
    logic [3:0]  din;
    int          cycles;
    logic [11:0] exp_pc;
    logic [3:0]  exp_acc;
    logic        exp_c;
    logic        exp_z;
    logic [3:0]  exp_dout;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM read is combinational on pc.
  assign bus.prog_byte = rom[bus.pc];

  // ALU: 001 a-b with borrow, 010 pass b, 011 a+b with carry, 100 nand.
  logic [4:0] alu_r;
  always_comb begin
    alu_r = {1'b0, bus.alu_a};
    case (bus.alu_sel)
      3'b001:  alu_r = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'b010:  alu_r = {1'b0, bus.alu_b};
      3'b011:  alu_r = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b100:  alu_r = {1'b0, ~(bus.alu_a & bus.alu_b)};
      default: alu_r = {1'b0, bus.alu_a};
    endcase
  end
  assign bus.alu_y    = alu_r[3:0];
  assign bus.alu_c    = alu_r[4];
  assign bus.alu_zero = (alu_r[3:0] == 4'h0);

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clearRom();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearRom();
    rom[0] = v.prog[31:24];
    rom[1] = v.prog[23:16];
    rom[2] = v.prog[15:8];
    rom[3] = v.prog[7:0];
    bus.data_in = v.din;
    bus.run     = 1'b1;
    doReset();
    runCycles(v.cycles);
    checkOutput({v.name, ".pc"},    bus.pc,                v.exp_pc);
    checkOutput({v.name, ".acc"},   {8'h0, bus.acc},       {8'h0, v.exp_acc});
    checkOutput({v.name, ".c"},     {11'h0, bus.flag_c},   {11'h0, v.exp_c});
    checkOutput({v.name, ".z"},     {11'h0, bus.flag_z},   {11'h0, v.exp_z});
    checkOutput({v.name, ".dout"},  {8'h0, bus.data_out},  {8'h0, v.exp_dout});
    checkOutput({v.name, ".state"}, {10'h0, bus.state},    {10'h0, v.exp_state});
  endtask

  initial begin
    vec_count   = 0;
    miss_count  = 0;
    rst_n       = 1'b0;
    bus.run     = 1'b1;
    bus.data_in = 4'h0;
    clearRom();

    //           name         program        din  cyc  pc      acc   c     z     dout  state
    vecs[0]  = '{"lit_addi",  32'h152C0000, 4'h0, 4, 12'h002, 4'h1, 1'b1, 1'b0, 4'h0, 2'b00};
    vecs[1]  = '{"lit_cmpi",  32'h13430000, 4'h0, 4, 12'h002, 4'h3, 1'b0, 1'b1, 4'h0, 2'b00};
    vecs[2]  = '{"jz_taken",  32'h10A12300, 4'h0, 4, 12'h123, 4'h0, 1'b0, 1'b1, 4'h0, 2'b00};
    vecs[3]  = '{"jz_not",    32'h11A12300, 4'h0, 4, 12'h003, 4'h1, 1'b0, 1'b0, 4'h0, 2'b00};
    vecs[4]  = '{"lit_out",   32'h19700000, 4'h0, 4, 12'h002, 4'h9, 1'b0, 1'b0, 4'h9, 2'b00};
    vecs[5]  = '{"subi_brw",  32'h12350000, 4'h0, 4, 12'h002, 4'hD, 1'b1, 1'b0, 4'h0, 2'b00};
    vecs[6]  = '{"nandi_c",   32'h1F215F00, 4'h0, 6, 12'h003, 4'hF, 1'b1, 1'b0, 4'h0, 2'b00};
    vecs[7]  = '{"in_port",   32'h60000000, 4'hA, 2, 12'h001, 4'hA, 1'b0, 1'b0, 4'h0, 2'b00};
    vecs[8]  = '{"jc_taken",  32'h1F219345, 4'h0, 6, 12'h345, 4'h0, 1'b1, 1'b1, 4'h0, 2'b00};
    vecs[9]  = '{"jnc_not",   32'h1F21B345, 4'h0, 6, 12'h004, 4'h0, 1'b1, 1'b1, 4'h0, 2'b00};
    vecs[10] = '{"jnz_taken", 32'h11C01000, 4'h0, 4, 12'h010, 4'h1, 1'b0, 1'b0, 4'h0, 2'b00};
    vecs[11] = '{"op_d_nop",  32'h17D50000, 4'h0, 4, 12'h002, 4'h7, 1'b0, 1'b0, 4'h0, 2'b00};

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Reset asserted during EXEC of ADDI: state clears without a clock
    // edge, and the restart fetches from address 0 again.
    clearRom();
    rom[0] = 8'h15;
    rom[1] = 8'h2C;
    bus.data_in = 4'h0;
    doReset();
    runCycles(3);
    checkOutput("rst_mid.pre_state", {10'h0, bus.state},   12'h001);
    checkOutput("rst_mid.pre_sel",   {9'h0, bus.alu_sel},  12'h003);
    checkOutput("rst_mid.pre_a",     {8'h0, bus.alu_a},    12'h005);
    checkOutput("rst_mid.pre_b",     {8'h0, bus.alu_b},    12'h00C);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid.acc",   {8'h0, bus.acc},      12'h000);
    checkOutput("rst_mid.pc",    bus.pc,               12'h000);
    checkOutput("rst_mid.state", {10'h0, bus.state},   12'h000);
    checkOutput("rst_mid.c",     {11'h0, bus.flag_c},  12'h000);
    checkOutput("rst_mid.z",     {11'h0, bus.flag_z},  12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    runCycles(2);
    checkOutput("rst_mid.refetch_acc", {8'h0, bus.acc}, 12'h005);
    checkOutput("rst_mid.refetch_pc",  bus.pc,          12'h001);

    // OUT strobe width, then run=0 freezing state and dropping the strobe.
    clearRom();
    rom[0] = 8'h19;
    rom[1] = 8'h70;
    doReset();
    runCycles(3);
    checkOutput("out.we_before", {11'h0, bus.out_we},  12'h000);
    checkOutput("out.sel_exec",  {9'h0, bus.alu_sel},  12'h000);
    runCycles(1);
    checkOutput("out.we_pulse",  {11'h0, bus.out_we},  12'h001);
    checkOutput("out.dout",      {8'h0, bus.data_out}, 12'h009);
    bus.run = 1'b0;
    runCycles(3);
    checkOutput("hold.we",    {11'h0, bus.out_we},  12'h000);
    checkOutput("hold.pc",    bus.pc,               12'h002);
    checkOutput("hold.acc",   {8'h0, bus.acc},      12'h009);
    checkOutput("hold.state", {10'h0, bus.state},   12'h000);
    checkOutput("hold.dout",  {8'h0, bus.data_out}, 12'h009);
    bus.run = 1'b1;
    runCycles(1);
    checkOutput("resume.pc",    bus.pc,             12'h003);
    checkOutput("resume.state", {10'h0, bus.state}, 12'h001);
    checkOutput("resume.we",    {11'h0, bus.out_we}, 12'h000);

    // Jump to 0xFFF, whose NOP fetch wraps pc to 0x000.
    clearRom();
    rom[0] = 8'h8F;
    rom[1] = 8'hFF;
    doReset();
    runCycles(1);
    checkOutput("wrap.addr_state", {10'h0, bus.state},  12'h002);
    checkOutput("wrap.addr_sel",   {9'h0, bus.alu_sel}, 12'h000);
    runCycles(1);
    checkOutput("wrap.jump_pc",    bus.pc,              12'hFFF);
    runCycles(1);
    checkOutput("wrap.pc",         bus.pc,              12'h000);
    checkOutput("wrap.state",      {10'h0, bus.state},  12'h001);
    checkOutput("wrap.c",          {11'h0, bus.flag_c}, 12'h000);
    runCycles(2);
    checkOutput("wrap.refetch_pc",    bus.pc,             12'h001);
    checkOutput("wrap.refetch_state", {10'h0, bus.state}, 12'h002);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
